// File: rtl/classifier_window_scheduler.sv
// Steps the classifier window one position per frame over a raster of positions,
// tracks the best-scoring window and publishes one detection result per full scan.
module classifier_window_scheduler #(
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480,
  parameter int WIN_W   = 64,
  parameter int WIN_H   = 64,
  parameter int STEP_X  = 32,
  parameter int STEP_Y  = 32
) (
  input  logic               clock_50,
  input  logic               reset,
  input  logic               enable,
  input  logic [12:0]        true_x,
  input  logic [12:0]        true_y,
  input  logic signed [31:0] frame_sum,
  output logic [12:0]        win_x_min,
  output logic [12:0]        win_x_max,
  output logic [12:0]        win_y_min,
  output logic [12:0]        win_y_max,
  output logic               scanning,
  output logic               result_valid,
  output logic               detect,
  output logic [12:0]        best_x,
  output logic [12:0]        best_y,
  output logic signed [31:0] best_sum
);

  typedef enum logic [1:0] {IDLE, PRIME, SCAN} state_t;

  localparam logic signed [31:0] SUM_MIN = 32'sh8000_0000;
  localparam logic [12:0] WIN_W13 = 13'(WIN_W);
  localparam logic [12:0] WIN_H13 = 13'(WIN_H);

  state_t             state_q, state_d;
  logic [12:0]        x_q, x_d, y_q, y_d;
  logic [12:0]        cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic               pend_q, pend_d, last_q, last_d;
  logic signed [31:0] run_sum_q, run_sum_d;
  logic [12:0]        run_x_q, run_x_d, run_y_q, run_y_d;
  logic signed [31:0] best_sum_q, best_sum_d;
  logic [12:0]        best_x_q, best_x_d, best_y_q, best_y_d;
  logic               detect_q, detect_d, rv_q, rv_d;

  logic               mark;
  logic [13:0]        nx, ny;
  logic signed [31:0] cand_sum;
  logic [12:0]        cand_x, cand_y;

  assign mark = (true_x == 13'd1) && (true_y == 13'd0);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    pend_d     = pend_q;
    last_d     = last_q;
    run_sum_d  = run_sum_q;
    run_x_d    = run_x_q;
    run_y_d    = run_y_q;
    best_sum_d = best_sum_q;
    best_x_d   = best_x_q;
    best_y_d   = best_y_q;
    detect_d   = detect_q;
    rv_d       = 1'b0;

    // Running best including the sample arriving this cycle; ties keep the earlier window.
    cand_sum = run_sum_q;
    cand_x   = run_x_q;
    cand_y   = run_y_q;
    if (pend_q && (frame_sum > run_sum_q)) begin
      cand_sum = frame_sum;
      cand_x   = cur_x_q;
      cand_y   = cur_y_q;
    end

    nx = {1'b0, x_q} + 14'(STEP_X);
    ny = {1'b0, y_q} + 14'(STEP_Y);

    case (state_q)
      IDLE: begin
        if (enable) state_d = PRIME;
      end
      PRIME: begin
        if (!enable) begin
          state_d   = IDLE;
          x_d       = '0;
          y_d       = '0;
          pend_d    = 1'b0;
          last_d    = 1'b0;
          run_sum_d = SUM_MIN;
        end else if (mark) begin
          x_d     = '0;
          y_d     = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (pend_q && last_q) begin
          best_sum_d = cand_sum;
          best_x_d   = cand_x;
          best_y_d   = cand_y;
          detect_d   = (cand_sum > 32'sd0);
          rv_d       = 1'b1;
          run_sum_d  = SUM_MIN;
          pend_d     = 1'b0;
          last_d     = 1'b0;
          if (!enable) begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
          end
        end else if (!enable) begin
          state_d   = IDLE;
          x_d       = '0;
          y_d       = '0;
          pend_d    = 1'b0;
          last_d    = 1'b0;
          run_sum_d = SUM_MIN;
        end else begin
          if (pend_q) begin
            run_sum_d = cand_sum;
            run_x_d   = cand_x;
            run_y_d   = cand_y;
            pend_d    = 1'b0;
          end
          if (mark) begin
            pend_d  = 1'b1;
            cur_x_d = x_q;
            cur_y_d = y_q;
            if ((nx + 14'(WIN_W)) > 14'(FRAME_W)) begin
              x_d = '0;
              if ((ny + 14'(WIN_H)) > 14'(FRAME_H)) begin
                y_d    = '0;
                last_d = 1'b1;
              end else begin
                y_d = ny[12:0];
              end
            end else begin
              x_d = nx[12:0];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      pend_q     <= 1'b0;
      last_q     <= 1'b0;
      run_sum_q  <= SUM_MIN;
      run_x_q    <= '0;
      run_y_q    <= '0;
      best_sum_q <= '0;
      best_x_q   <= '0;
      best_y_q   <= '0;
      detect_q   <= 1'b0;
      rv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      pend_q     <= pend_d;
      last_q     <= last_d;
      run_sum_q  <= run_sum_d;
      run_x_q    <= run_x_d;
      run_y_q    <= run_y_d;
      best_sum_q <= best_sum_d;
      best_x_q   <= best_x_d;
      best_y_q   <= best_y_d;
      detect_q   <= detect_d;
      rv_q       <= rv_d;
    end
  end

  assign win_x_min    = x_q;
  assign win_x_max    = x_q + WIN_W13;
  assign win_y_min    = y_q;
  assign win_y_max    = y_q + WIN_H13;
  assign scanning     = (state_q != IDLE);
  assign result_valid = rv_q;
  assign detect       = detect_q;
  assign best_x       = best_x_q;
  assign best_y       = best_y_q;
  assign best_sum     = best_sum_q;

endmodule

// File: tb/tb_classifier_window_scheduler.sv
// Directed bench for the window scheduler on a 16x8 frame with four 8x4 window positions.
module tb_classifier_window_scheduler;

  logic               clk;
  logic               rst;
  logic               enable;
  logic [12:0]        true_x, true_y;
  logic signed [31:0] frame_sum;
  logic [12:0]        win_x_min, win_x_max, win_y_min, win_y_max;
  logic               scanning, result_valid, detect;
  logic [12:0]        best_x, best_y;
  logic signed [31:0] best_sum;

  int checks = 0;
  int errors = 0;
  int rv_count = 0;
  logic [12:0] exp_wx = 13'd0;
  logic [12:0] exp_wy = 13'd0;

  classifier_window_scheduler #(
    .FRAME_W(16), .FRAME_H(8), .WIN_W(8), .WIN_H(4), .STEP_X(8), .STEP_Y(4)
  ) dut (
    .clock_50    (clk),
    .reset       (rst),
    .enable      (enable),
    .true_x      (true_x),
    .true_y      (true_y),
    .frame_sum   (frame_sum),
    .win_x_min   (win_x_min),
    .win_x_max   (win_x_max),
    .win_y_min   (win_y_min),
    .win_y_max   (win_y_max),
    .scanning    (scanning),
    .result_valid(result_valid),
    .detect      (detect),
    .best_x      (best_x),
    .best_y      (best_y),
    .best_sum    (best_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (result_valid) rv_count <= rv_count + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_win(input string tag);
    chk({tag, ".xmin"}, 32'(win_x_min), 32'(exp_wx));
    chk({tag, ".ymin"}, 32'(win_y_min), 32'(exp_wy));
    chk({tag, ".xmax"}, 32'(win_x_max), 32'(exp_wx + 13'd8));
    chk({tag, ".ymax"}, 32'(win_y_max), 32'(exp_wy + 13'd4));
  endtask

  // Mark cycle, then the cycle carrying the classifier's latched sum, then one quiet cycle.
  task automatic do_mark(input string tag, input logic signed [31:0] sum,
                         input logic [12:0] nwx, input logic [12:0] nwy, input logic exp_rv);
    chk_win({tag, ".pre"});
    true_x    = 13'd1;
    true_y    = 13'd0;
    frame_sum = 32'sh0BAD_BEEF;
    tick();
    exp_wx = nwx;
    exp_wy = nwy;
    chk_win({tag, ".mark"});
    true_x    = 13'd0;
    true_y    = 13'd3;
    frame_sum = sum;
    tick();
    chk({tag, ".rv"}, 32'(result_valid), 32'(exp_rv));
    frame_sum = 32'sh7FFF_FFFF;
    tick();
    chk({tag, ".rv_off"}, 32'(result_valid), 32'd0);
    chk_win({tag, ".hold"});
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; true_x = 13'd0; true_y = 13'd3; frame_sum = '0;
    tick(); tick();
    chk("rst.xmin", 32'(win_x_min), 32'd0);
    chk("rst.xmax", 32'(win_x_max), 32'd8);
    chk("rst.ymin", 32'(win_y_min), 32'd0);
    chk("rst.ymax", 32'(win_y_max), 32'd4);
    chk("rst.scanning", 32'(scanning), 32'd0);
    chk("rst.rv", 32'(result_valid), 32'd0);
    chk("rst.detect", 32'(detect), 32'd0);
    chk("rst.best_x", 32'(best_x), 32'd0);
    chk("rst.best_y", 32'(best_y), 32'd0);
    chk("rst.best_sum", best_sum, 32'd0);

    rst = 1'b0;
    tick();
    chk("prime.scanning", 32'(scanning), 32'd1);

    // First scan: sum after the PRIME mark is discarded
    do_mark("m1", 32'sd99, 13'd0, 13'd0, 1'b0);
    do_mark("m2", 32'sd5,  13'd8, 13'd0, 1'b0);
    do_mark("m3", 32'sd20, 13'd0, 13'd4, 1'b0);
    do_mark("m4", -32'sd3, 13'd8, 13'd4, 1'b0);
    do_mark("m5", 32'sd20, 13'd0, 13'd0, 1'b1);
    chk("s1.count", 32'(rv_count), 32'd1);
    chk("s1.best_x", 32'(best_x), 32'd8);
    chk("s1.best_y", 32'(best_y), 32'd0);
    chk("s1.best_sum", best_sum, 32'd20);
    chk("s1.detect", 32'(detect), 32'd1);
    chk("s1.scanning", 32'(scanning), 32'd1);

    // Second scan follows immediately with no PRIME frame
    do_mark("m6", -32'sd1, 13'd8, 13'd0, 1'b0);
    do_mark("m7", -32'sd7, 13'd0, 13'd4, 1'b0);
    do_mark("m8", -32'sd2, 13'd8, 13'd4, 1'b0);
    do_mark("m9", -32'sd9, 13'd0, 13'd0, 1'b1);
    chk("s2.count", 32'(rv_count), 32'd2);
    chk("s2.best_x", 32'(best_x), 32'd0);
    chk("s2.best_y", 32'(best_y), 32'd0);
    chk("s2.best_sum", best_sum, 32'hFFFF_FFFF);
    chk("s2.detect", 32'(detect), 32'd0);

    // Abort a third scan after its third position is applied
    do_mark("m10", 32'sd7,   13'd8, 13'd0, 1'b0);
    do_mark("m11", 32'sd100, 13'd0, 13'd4, 1'b0);
    enable = 1'b0;
    tick();
    chk("abort.scanning", 32'(scanning), 32'd0);
    exp_wx = 13'd0;
    exp_wy = 13'd0;
    chk_win("abort");
    do_mark("idle1", 32'sd500, 13'd0, 13'd0, 1'b0);
    do_mark("idle2", 32'sd600, 13'd0, 13'd0, 1'b0);
    chk("abort.scanning2", 32'(scanning), 32'd0);
    chk("abort.count", 32'(rv_count), 32'd2);
    chk("abort.best_sum", best_sum, 32'hFFFF_FFFF);
    chk("abort.best_x", 32'(best_x), 32'd0);
    chk("abort.detect", 32'(detect), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
